// File: rtl/icache_refill_pkg.sv
// Shared constants for the instruction-cache refill path and the 8-line
// direct-mapped cache it feeds.
package icache_refill_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2,
        HOLD = 2'd3
    } refill_state_t;

    localparam int LINE_WORDS = 4;
    localparam int LINE_BITS  = 128;
    localparam int OFFSET_LSB = 2;
    localparam int INDEX_LSB  = 4;
    localparam int TAG_LSB    = 7;

    localparam logic [31:0] NOP_INST  = 32'h0800_0000;
    localparam logic [31:0] LINE_MASK = 32'hFFFF_FFF0;

endpackage

// File: rtl/icache_refill_if.sv
// Request/acknowledge read bus between the refill engine and instruction memory.
interface icache_refill_if;

    logic        memReq;
    logic [31:0] memAddr;
    logic        memAck;
    logic [31:0] memRdata;

    modport master (
        output memReq,
        output memAddr,
        input  memAck,
        input  memRdata
    );

    modport slave (
        input  memReq,
        input  memAddr,
        output memAck,
        output memRdata
    );

endinterface

// File: rtl/icache_refill.sv
// Fetches the 16-byte line holding a missed fetch address as four word reads
// and hands the assembled line to the cache fill port.
module icache_refill
    import icache_refill_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 miss,
    input  logic [31:0]          missAddr,
    icache_refill_if.master      mem,
    output logic [LINE_BITS-1:0] lineData,
    output logic [31:0]          lineAddr,
    output logic                 lineValid,
    output logic                 busy,
    output logic                 refillErr
);

    // Abort fires on the edge where the wait count would reach TIMEOUT.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    refill_state_t state, nextState;

    logic [31:0] base;
    logic [31:0] missBase;
    logic [1:0]  beat;
    logic [7:0]  waitCnt;
    logic [95:0] wordBuf;
    logic        accept;
    logic        expired;

    assign missBase = missAddr & LINE_MASK;
    assign busy     = (state != IDLE);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // An ack on the timeout edge still counts as a delivered beat.
    always_comb begin
        nextState = state;
        accept    = 1'b0;
        expired   = 1'b0;
        case (state)
            IDLE: begin
                if (miss) begin
                    nextState = REQ;
                end
            end
            REQ: begin
                if (mem.memReq && mem.memAck) begin
                    accept = 1'b1;
                    if (beat == 2'd3) begin
                        nextState = FILL;
                    end
                end else if (waitCnt == WAIT_LAST) begin
                    expired   = 1'b1;
                    nextState = IDLE;
                end
            end
            FILL:    nextState = HOLD;
            HOLD:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Words 0..2 shift into wordBuf; the last word goes straight into lineData.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            mem.memReq  <= 1'b0;
            mem.memAddr <= '0;
            base        <= '0;
            beat        <= '0;
            waitCnt     <= '0;
            wordBuf     <= '0;
            lineData    <= '0;
            lineAddr    <= '0;
            lineValid   <= 1'b0;
            refillErr   <= 1'b0;
        end else begin
            lineValid <= 1'b0;
            refillErr <= 1'b0;
            if (state == IDLE && miss) begin
                base        <= missBase;
                beat        <= '0;
                waitCnt     <= '0;
                mem.memReq  <= 1'b1;
                mem.memAddr <= missBase;
            end else if (accept) begin
                waitCnt <= '0;
                if (beat == 2'd3) begin
                    mem.memReq <= 1'b0;
                    lineValid  <= 1'b1;
                    lineAddr   <= base;
                    lineData   <= {mem.memRdata, wordBuf};
                end else begin
                    beat        <= beat + 2'd1;
                    wordBuf     <= {mem.memRdata, wordBuf[95:32]};
                    mem.memAddr <= {base[31:INDEX_LSB], beat + 2'd1, 2'b00};
                end
            end else if (expired) begin
                refillErr  <= 1'b1;
                mem.memReq <= 1'b0;
            end else if (state == REQ) begin
                waitCnt <= waitCnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_icache_refill.sv
// Directed bench for icache_refill: a memory responder with programmable ack
// delay, a monitor logging bus/line events, and hand-computed expected lines.
module tb_icache_refill;

    logic         Clk;
    logic         Rst;
    logic         miss;
    logic [31:0]  missAddr;
    logic [127:0] lineData;
    logic [31:0]  lineAddr;
    logic         lineValid;
    logic         busy;
    logic         refillErr;

    icache_refill_if memIf();

    icache_refill #(.TIMEOUT(8)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .miss      (miss),
        .missAddr  (missAddr),
        .mem       (memIf),
        .lineData  (lineData),
        .lineAddr  (lineAddr),
        .lineValid (lineValid),
        .busy      (busy),
        .refillErr (refillErr)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int missCyc;

    bit respOn   = 1'b1;
    bit forceAck = 1'b0;
    int ackDelay = 0;

    int unsigned  beatAddrQ[$];
    int unsigned  beatCycQ[$];
    int unsigned  reqRiseQ[$];
    int unsigned  lvCycQ[$];
    int unsigned  lvAddrQ[$];
    logic [127:0] lvDataQ[$];
    int unsigned  errCycQ[$];
    int unsigned  errReqQ[$];
    int unsigned  busyFallQ[$];
    int           busySamples;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    function automatic int unsigned qi(input int unsigned q[$], input int i);
        if (i < q.size()) return q[i];
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic [127:0] qv(input logic [127:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return '1;
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge Clk);
            #3;
        end
    endtask

    task automatic applyStimulus(input logic m, input logic [31:0] a);
        miss     = m;
        missAddr = a;
    endtask

    task automatic clearMon();
        beatAddrQ.delete();
        beatCycQ.delete();
        reqRiseQ.delete();
        lvCycQ.delete();
        lvAddrQ.delete();
        lvDataQ.delete();
        errCycQ.delete();
        errReqQ.delete();
        busyFallQ.delete();
        busySamples = 0;
    endtask

    task automatic waitBeats(input string tag, input int n, input int budget);
        int k = 0;
        while (beatAddrQ.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        checkOutput(tag, beatAddrQ.size(), n);
    endtask

    task automatic waitRises(input string tag, input int n, input int budget);
        int k = 0;
        while (reqRiseQ.size() < n && k < budget) begin
            tick(1);
            k++;
        end
        checkOutput(tag, reqRiseQ.size(), n);
    endtask

    // Memory model: acks each beat after ackDelay idle cycles of memReq.
    initial begin
        int stall = 0;
        bit prevAck = 1'b0;
        memIf.memAck   = 1'b0;
        memIf.memRdata = '0;
        forever begin
            @(negedge Clk);
            if (prevAck || !memIf.memReq) stall = 0;
            memIf.memAck = forceAck;
            if (forceAck) memIf.memRdata = 32'hDEAD_BEEF;
            if (respOn && memIf.memReq) begin
                if (stall == ackDelay) begin
                    memIf.memAck   = 1'b1;
                    memIf.memRdata = memWord(memIf.memAddr);
                end else begin
                    stall++;
                end
            end
            prevAck = memIf.memAck;
        end
    end

    initial begin
        bit prevReq  = 1'b0;
        bit prevBusy = 1'b0;
        busySamples = 0;
        forever begin
            @(negedge Clk);
            #2;
            cyc++;
            if (memIf.memReq && !prevReq) reqRiseQ.push_back(cyc);
            if (memIf.memReq && memIf.memAck) begin
                beatAddrQ.push_back(memIf.memAddr);
                beatCycQ.push_back(cyc);
            end
            if (lineValid) begin
                lvCycQ.push_back(cyc);
                lvAddrQ.push_back(lineAddr);
                lvDataQ.push_back(lineData);
            end
            if (refillErr) begin
                errCycQ.push_back(cyc);
                errReqQ.push_back({31'd0, memIf.memReq});
            end
            if (!busy && prevBusy) busyFallQ.push_back(cyc);
            if (busy) busySamples++;
            prevReq  = memIf.memReq;
            prevBusy = busy;
        end
    end

    initial begin
        Rst = 1'b1;
        applyStimulus(1'b0, 32'h0);
        tick(3);
        checkOutput("rst_memReq", memIf.memReq, 1'b0);
        checkOutput("rst_memAddr", memIf.memAddr, 32'h0);
        checkOutput("rst_lineValid", lineValid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_refillErr", refillErr, 1'b0);
        checkOutput("rst_lineData", lineData, 128'h0);
        checkOutput("rst_lineAddr", lineAddr, 32'h0);
        Rst = 1'b0;
        tick(2);

        $display("[TB] zero-wait refill at 0x48");
        clearMon();
        ackDelay = 0;
        applyStimulus(1'b1, 32'h0000_0048);
        missCyc = cyc;
        tick(1);
        applyStimulus(1'b0, 32'h0000_0048);
        tick(15);
        checkOutput("t1_beats", beatAddrQ.size(), 4);
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("t1_addr%0d", k), qi(beatAddrQ, k), 32'h40 + 32'(4 * k));
        checkOutput("t1_backToBack", qi(beatCycQ, 3) - qi(beatCycQ, 0), 3);
        checkOutput("t1_lines", lvCycQ.size(), 1);
        checkOutput("t1_latency", qi(lvCycQ, 0) - missCyc, 5);
        checkOutput("t1_lineAddr", qi(lvAddrQ, 0), 32'h40);
        checkOutput("t1_lineData", qv(lvDataQ, 0), 128'hC0DE004C_C0DE0048_C0DE0044_C0DE0040);
        checkOutput("t1_busyFall", qi(busyFallQ, 0) - qi(lvCycQ, 0), 2);
        checkOutput("t1_noErr", errCycQ.size(), 0);

        $display("[TB] 3-wait refill at 0x12345670");
        clearMon();
        ackDelay = 3;
        applyStimulus(1'b1, 32'h1234_5670);
        missCyc = cyc;
        tick(1);
        applyStimulus(1'b0, 32'h1234_5670);
        tick(30);
        checkOutput("t2_beats", beatAddrQ.size(), 4);
        for (int k = 0; k < 4; k++)
            checkOutput($sformatf("t2_addr%0d", k), qi(beatAddrQ, k), 32'h1234_5670 + 32'(4 * k));
        checkOutput("t2_firstAck", qi(beatCycQ, 0) - missCyc, 4);
        checkOutput("t2_hold01", qi(beatCycQ, 1) - qi(beatCycQ, 0), 4);
        checkOutput("t2_hold23", qi(beatCycQ, 3) - qi(beatCycQ, 2), 4);
        checkOutput("t2_lines", lvCycQ.size(), 1);
        checkOutput("t2_lineAddr", qi(lvAddrQ, 0), 32'h1234_5670);
        checkOutput("t2_lineData", qv(lvDataQ, 0), 128'hC0DE567C_C0DE5678_C0DE5674_C0DE5670);
        checkOutput("t2_noErr", errCycQ.size(), 0);

        $display("[TB] no ack, timeout abort");
        clearMon();
        respOn = 1'b0;
        applyStimulus(1'b1, 32'h0000_0500);
        tick(1);
        applyStimulus(1'b0, 32'h0000_0500);
        tick(20);
        checkOutput("t3_errCount", errCycQ.size(), 1);
        checkOutput("t3_errDelay", qi(errCycQ, 0) - qi(reqRiseQ, 0), 8);
        checkOutput("t3_errReqLow", qi(errReqQ, 0), 0);
        checkOutput("t3_noLine", lvCycQ.size(), 0);
        checkOutput("t3_busyNext", qi(busyFallQ, 0) <= qi(errCycQ, 0) + 1, 1'b1);
        checkOutput("t3_memReqEnd", memIf.memReq, 1'b0);
        respOn = 1'b1;

        $display("[TB] ack on the timeout cycle");
        clearMon();
        ackDelay = 7;
        applyStimulus(1'b1, 32'h0000_0200);
        tick(1);
        applyStimulus(1'b0, 32'h0000_0200);
        tick(45);
        checkOutput("t7_noErr", errCycQ.size(), 0);
        checkOutput("t7_ackAt8", qi(beatCycQ, 0) - qi(reqRiseQ, 0), 7);
        checkOutput("t7_lines", lvCycQ.size(), 1);
        checkOutput("t7_lineData", qv(lvDataQ, 0), 128'hC0DE020C_C0DE0208_C0DE0204_C0DE0200);

        $display("[TB] miss held, missAddr changed mid-refill");
        clearMon();
        ackDelay = 1;
        applyStimulus(1'b1, 32'h0000_00C4);
        tick(3);
        applyStimulus(1'b1, 32'h0000_0100);
        waitRises("t4_secondRefill", 2, 30);
        applyStimulus(1'b0, 32'h0000_0100);
        tick(20);
        checkOutput("t4_lines", lvCycQ.size(), 2);
        checkOutput("t4_lineAddr0", qi(lvAddrQ, 0), 32'hC0);
        checkOutput("t4_lineData0", qv(lvDataQ, 0), 128'hC0DE00CC_C0DE00C8_C0DE00C4_C0DE00C0);
        checkOutput("t4_holdIgnored", qi(reqRiseQ, 1) - qi(lvCycQ, 0), 3);
        checkOutput("t4_lineAddr1", qi(lvAddrQ, 1), 32'h100);
        checkOutput("t4_lineData1", qv(lvDataQ, 1), 128'hC0DE010C_C0DE0108_C0DE0104_C0DE0100);
        checkOutput("t4_beats", beatAddrQ.size(), 8);

        $display("[TB] reset during beat 2");
        clearMon();
        ackDelay = 2;
        applyStimulus(1'b1, 32'h0000_0030);
        tick(1);
        applyStimulus(1'b0, 32'h0000_0030);
        waitBeats("t5_twoBeats", 2, 30);
        tick(1);
        Rst = 1'b1;
        tick(1);
        checkOutput("t5_memReq", memIf.memReq, 1'b0);
        checkOutput("t5_memAddr", memIf.memAddr, 32'h0);
        checkOutput("t5_lineData", lineData, 128'h0);
        checkOutput("t5_lineAddr", lineAddr, 32'h0);
        checkOutput("t5_lineValid", lineValid, 1'b0);
        checkOutput("t5_busy", busy, 1'b0);
        checkOutput("t5_refillErr", refillErr, 1'b0);
        checkOutput("t5_noPartialLine", lvCycQ.size(), 0);
        Rst = 1'b0;
        tick(1);
        clearMon();
        ackDelay = 0;
        applyStimulus(1'b1, 32'h0000_0080);
        tick(1);
        applyStimulus(1'b0, 32'h0000_0080);
        tick(15);
        checkOutput("t5_lines", lvCycQ.size(), 1);
        checkOutput("t5_newLineAddr", qi(lvAddrQ, 0), 32'h80);
        checkOutput("t5_newLineData", qv(lvDataQ, 0), 128'hC0DE008C_C0DE0088_C0DE0084_C0DE0080);

        $display("[TB] stray memAck while idle");
        clearMon();
        respOn   = 1'b0;
        forceAck = 1'b1;
        tick(4);
        forceAck = 1'b0;
        tick(2);
        checkOutput("t6_busy", busySamples, 0);
        checkOutput("t6_noLine", lvCycQ.size(), 0);
        checkOutput("t6_memReq", memIf.memReq, 1'b0);
        checkOutput("t6_lineKept", lineData, 128'hC0DE008C_C0DE0088_C0DE0084_C0DE0080);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
